alu_op_decoder: RTL and testbench
=================================

Name: alu_op_decoder

Overview:
- Decode stage that produces the operation code and operands consumed by the ALU. It is the producing end of the ALU operation interface.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes the supported ALU subset: ADD, SUB, AND, XOR, SRA and their immediate forms.
- Emits a registered decode bundle through a 2-entry skid buffer, so the stage sustains one instruction per cycle under backpressure.
- Sits between instruction fetch and the register-read/ALU stage.

Parameters:
- SIZE, 32, datapath width; width of the sign-extended immediate output.
- ALUOP_BITS, 3, width of the ALU operation code.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous discard of all buffered instructions.
- in_valid  input  1  instruction present on in_instr.
- in_ready  output  1  decoder can accept an instruction this cycle.
- in_instr  input  32  RV32I instruction word.
- out_valid  output  1  decode bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- alu_op  output  ALUOP_BITS  000 ADD, 001 SUB, 010 AND, 011 XOR, 100 SRA, 111 illegal/pass.
- rs1  output  5  source register 1 index.
- rs2  output  5  source register 2 index; 0 for I-type.
- rd  output  5  destination register index.
- imm  output  SIZE  sign-extended immediate (zero-extended shamt for SRAI); 0 for R-type.
- use_imm  output  1  operand 2 comes from imm, not from rs2.
- reg_write  output  1  write back rd.
- illegal  output  1  instruction is outside the supported subset.

Behaviour:
- Reset (async, rst=1): both skid entries empty; out_valid=0; in_ready=1; all bundle outputs 0.
- Decoding (combinational on in_instr, captured on accept):
  - opcode 0110011 with funct7 0000000: funct3 000 ADD, 111 AND, 100 XOR.
  - opcode 0110011 with funct7 0100000: funct3 000 SUB, 101 SRA.
  - opcode 0010011: funct3 000 ADDI, 111 ANDI, 100 XORI; imm = sign-extend(instr[31:20]).
  - opcode 0010011, funct3 101, instr[31:25]=0100000: SRAI; imm = {0, instr[24:20]}.
  - I-types: use_imm=1, rs2=0.
  - Any other encoding, including other funct7 values: illegal=1, alu_op=111, reg_write=0, use_imm=0, imm=0. rs1/rs2/rd are still passed through from the instruction fields.
  - rd=0 on a legal instruction: reg_write=0.
- Handshake:
  - An instruction is accepted when in_valid && in_ready.
  - The bundle is consumed when out_valid && out_ready.
  - Latency is 1 cycle from accept to out_valid when the stage is empty.
- Skid buffer states: EMPTY, ONE (main register valid), TWO (main + skid valid).
  - in_ready=1 in EMPTY and ONE; in_ready=0 in TWO. in_ready is a registered, state-derived signal.
  - EMPTY -accept-> ONE.
  - ONE -accept and no consume-> TWO.
  - ONE -consume and no accept-> EMPTY.
  - ONE -accept and consume-> ONE, main register loads the new bundle.
  - TWO -consume-> ONE, skid moves into main.
- Ordering: strictly FIFO. Outputs must be held stable while out_valid && !out_ready.
- flush=1: next state EMPTY, out_valid=0, in_ready=1.
  - Any instruction offered in the flush cycle is dropped, even if in_valid=1.
  - flush has priority over accept and consume.
- Reset mid-operation: buffered contents are lost immediately; out_valid drops asynchronously.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Test Plan:
- Reset, then offer 0x002081B3 (add x3,x1,x2) with out_ready=1 -> next cycle out_valid=1, alu_op=000, rs1=1, rs2=2, rd=3, use_imm=0, reg_write=1, illegal=0.
- Back-to-back 0x402081B3, 0x0020C233, 0xFFF00293 with out_ready=1 -> one bundle per cycle in order:
  - SUB (001).
  - XOR (011).
  - ADDI: alu_op=000, rd=5, imm=0xFFFFFFFF, use_imm=1.
- 0x4033D313 (srai x6,x7,3) -> alu_op=100, rs1=7, rd=6, imm=3, use_imm=1.
- 0x0000A083 (lw) -> illegal=1, alu_op=111, reg_write=0. The next instruction still decodes normally.
- Backpressure: out_ready=0 while 3 instructions are offered -> first 2 accepted, in_ready=0 on the third, first bundle held stable. Raise out_ready -> all 3 delivered in order with no loss or duplication.
- flush in state TWO with in_valid=1 -> out_valid=0 next cycle, in_ready=1, and no flushed or in-flush instruction is ever emitted.

Source files
------------

// File: rtl/alu_op_decoder_if.sv
// ALU operation bundle interface: decode stage (master) to register-read/ALU stage (slave).
interface alu_op_decoder_if #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned ALUOP_BITS = 3
);
   logic                  out_valid;
   logic                  out_ready;
   logic [ALUOP_BITS-1:0] alu_op;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [4:0]            rd;
   logic [SIZE-1:0]       imm;
   logic                  use_imm;
   logic                  reg_write;
   logic                  illegal;

   modport master (
      output out_valid, alu_op, rs1, rs2, rd, imm, use_imm, reg_write, illegal,
      input  out_ready
   );

   modport slave (
      input  out_valid, alu_op, rs1, rs2, rd, imm, use_imm, reg_write, illegal,
      output out_ready
   );
endinterface

// File: rtl/alu_op_decoder.sv
// RV32I ALU-subset decoder (ADD/SUB/AND/XOR/SRA + immediates) feeding a 2-entry skid buffer.
module alu_op_decoder #(
   parameter int unsigned SIZE       = 32,
   parameter int unsigned ALUOP_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   alu_op_decoder_if.master     alu
);

   typedef struct packed {
      logic [ALUOP_BITS-1:0] alu_op;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
      logic [SIZE-1:0]       imm;
      logic                  use_imm;
      logic                  reg_write;
      logic                  illegal;
   } bundle_t;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   localparam logic [ALUOP_BITS-1:0] OpAdd  = ALUOP_BITS'(3'b000);
   localparam logic [ALUOP_BITS-1:0] OpSub  = ALUOP_BITS'(3'b001);
   localparam logic [ALUOP_BITS-1:0] OpAnd  = ALUOP_BITS'(3'b010);
   localparam logic [ALUOP_BITS-1:0] OpXor  = ALUOP_BITS'(3'b011);
   localparam logic [ALUOP_BITS-1:0] OpSra  = ALUOP_BITS'(3'b100);
   localparam logic [ALUOP_BITS-1:0] OpIll  = ALUOP_BITS'(3'b111);

   state_e  state_q, state_d;
   bundle_t main_q, main_d;
   bundle_t skid_q, skid_d;
   bundle_t dec;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal;
   logic       itype;
   logic       accept;
   logic       consume;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   always_comb begin
      legal  = 1'b0;
      itype  = 1'b0;
      dec    = '0;
      dec.alu_op = OpIll;
      if (opcode == 7'b0110011 && funct7 == 7'b0000000) begin
         unique case (funct3)
            3'b000:  begin legal = 1'b1; dec.alu_op = OpAdd; end
            3'b111:  begin legal = 1'b1; dec.alu_op = OpAnd; end
            3'b100:  begin legal = 1'b1; dec.alu_op = OpXor; end
            default: ;
         endcase
      end else if (opcode == 7'b0110011 && funct7 == 7'b0100000) begin
         unique case (funct3)
            3'b000:  begin legal = 1'b1; dec.alu_op = OpSub; end
            3'b101:  begin legal = 1'b1; dec.alu_op = OpSra; end
            default: ;
         endcase
      end else if (opcode == 7'b0010011) begin
         itype   = 1'b1;
         dec.imm = {{(SIZE-12){in_instr[31]}}, in_instr[31:20]};
         unique case (funct3)
            3'b000:  begin legal = 1'b1; dec.alu_op = OpAdd; end
            3'b111:  begin legal = 1'b1; dec.alu_op = OpAnd; end
            3'b100:  begin legal = 1'b1; dec.alu_op = OpXor; end
            3'b101: begin
               // Only the arithmetic shift form is supported; shamt is zero-extended.
               if (funct7 == 7'b0100000) begin
                  legal      = 1'b1;
                  dec.alu_op = OpSra;
                  dec.imm    = {{(SIZE-5){1'b0}}, in_instr[24:20]};
               end
            end
            default: ;
         endcase
      end

      dec.rs1 = in_instr[19:15];
      dec.rd  = in_instr[11:7];
      dec.rs2 = (legal && itype) ? 5'd0 : in_instr[24:20];
      if (legal) begin
         dec.use_imm   = itype;
         dec.reg_write = (in_instr[11:7] != 5'd0);
         if (!itype) dec.imm = '0;
      end else begin
         dec.alu_op  = OpIll;
         dec.illegal = 1'b1;
         dec.imm     = '0;
      end
   end

   assign in_ready      = (state_q != StTwo);
   assign alu.out_valid = (state_q != StEmpty);
   assign accept        = in_valid && in_ready;
   assign consume       = alu.out_valid && alu.out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d = StOne;
                  main_d  = dec;
               end
            end
            StOne: begin
               if (accept && consume) begin
                  main_d = dec;
               end else if (accept) begin
                  state_d = StTwo;
                  skid_d  = dec;
               end else if (consume) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (consume) begin
                  state_d = StOne;
                  main_d  = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign alu.alu_op    = main_q.alu_op;
   assign alu.rs1       = main_q.rs1;
   assign alu.rs2       = main_q.rs2;
   assign alu.rd        = main_q.rd;
   assign alu.imm       = main_q.imm;
   assign alu.use_imm   = main_q.use_imm;
   assign alu.reg_write = main_q.reg_write;
   assign alu.illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed vector table, backpressure/flush/reset sequences,
// and randomized traffic scored against a queue-based model.
module tb_alu_op_decoder;

   typedef struct packed {
      logic [2:0]  alu_op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic        reg_write;
      logic        illegal;
   } bundle_t;

   typedef struct {
      logic [31:0] instr;
      bundle_t     exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;

   int n_vec = 0;
   int n_err = 0;
   bundle_t q[$];

   alu_op_decoder_if #(.SIZE(32), .ALUOP_BITS(3)) bus ();

   alu_op_decoder #(.SIZE(32), .ALUOP_BITS(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .alu      (bus)
   );

   always #5 clk = ~clk;

   function automatic bundle_t dut_bundle();
      bundle_t b;
      b.alu_op    = bus.alu_op;
      b.rs1       = bus.rs1;
      b.rs2       = bus.rs2;
      b.rd        = bus.rd;
      b.imm       = bus.imm;
      b.use_imm   = bus.use_imm;
      b.reg_write = bus.reg_write;
      b.illegal   = bus.illegal;
      return b;
   endfunction

   // Reference decode from the instruction-set rules, mnemonic first.
   function automatic bundle_t ref_decode(input logic [31:0] w);
      bundle_t b;
      string   mn;
      logic [6:0] op = w[6:0];
      logic [2:0] f3 = w[14:12];
      logic [6:0] f7 = w[31:25];
      mn = "";
      if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) mn = "add";
      if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) mn = "and";
      if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) mn = "xor";
      if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) mn = "sub";
      if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd5) mn = "sra";
      if (op == 7'h13 && f3 == 3'd0) mn = "addi";
      if (op == 7'h13 && f3 == 3'd7) mn = "andi";
      if (op == 7'h13 && f3 == 3'd4) mn = "xori";
      if (op == 7'h13 && f3 == 3'd5 && f7 == 7'h20) mn = "srai";
      b = '0;
      b.rs1 = w[19:15];
      b.rd  = w[11:7];
      b.rs2 = w[24:20];
      case (mn)
         "add", "addi": b.alu_op = 3'd0;
         "sub":         b.alu_op = 3'd1;
         "and", "andi": b.alu_op = 3'd2;
         "xor", "xori": b.alu_op = 3'd3;
         "sra", "srai": b.alu_op = 3'd4;
         default: begin
            b.alu_op  = 3'd7;
            b.illegal = 1'b1;
         end
      endcase
      if (!b.illegal) begin
         b.reg_write = (b.rd != 0);
         if (op == 7'h13) begin
            b.use_imm = 1'b1;
            b.rs2     = 5'd0;
            if (mn == "srai") b.imm = 32'(w[24:20]);
            else              b.imm = 32'($signed(w[31:20]));
         end
      end
      return b;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      cmp("in_ready", 64'(in_ready), 64'(q.size() < 2));
      cmp("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      if (q.size() > 0) cmp("bundle", 64'(dut_bundle()), 64'(q[0]));
   endtask

   // Drive one cycle: inputs applied away from the edge, outputs checked, model advanced.
   task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
      logic acc, con;
      in_valid = v;
      in_instr = ins;
      bus.out_ready = ordy;
      flush = fl;
      #1;
      check_model();
      acc = v && (q.size() < 2);
      con = ordy && (q.size() > 0);
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         if (con) void'(q.pop_front());
         if (acc) q.push_back(ref_decode(ins));
      end
   endtask

   function automatic bundle_t mk(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] d, input logic [31:0] im, input logic ui,
                                  input logic rw, input logic il);
      bundle_t b;
      b.alu_op = op; b.rs1 = r1; b.rs2 = r2; b.rd = d; b.imm = im;
      b.use_imm = ui; b.reg_write = rw; b.illegal = il;
      return b;
   endfunction

   vec_t vt[$];
   bundle_t first_b;

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      bus.out_ready = 1'b0;
      #3;
      cmp("rst_out_valid", 64'(bus.out_valid), 64'd0);
      cmp("rst_in_ready", 64'(in_ready), 64'd1);
      cmp("rst_bundle", 64'(dut_bundle()), 64'd0);
      #8 rst = 1'b0;

      vt.push_back('{32'h002081B3, mk(3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b0)});
      vt.push_back('{32'h402081B3, mk(3'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b0)});
      vt.push_back('{32'h0020C233, mk(3'd3, 5'd1, 5'd2, 5'd4, 32'd0, 1'b0, 1'b1, 1'b0)});
      vt.push_back('{32'hFFF00293, mk(3'd0, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0)});
      vt.push_back('{32'h4033D313, mk(3'd4, 5'd7, 5'd0, 5'd6, 32'd3, 1'b1, 1'b1, 1'b0)});
      vt.push_back('{32'h0000A083, mk(3'd7, 5'd1, 5'd0, 5'd1, 32'd0, 1'b0, 1'b0, 1'b1)});
      vt.push_back('{32'h00A00093, mk(3'd0, 5'd0, 5'd0, 5'd1, 32'd10, 1'b1, 1'b1, 1'b0)});
      vt.push_back('{32'h007372B3, mk(3'd2, 5'd6, 5'd7, 5'd5, 32'd0, 1'b0, 1'b1, 1'b0)});
      vt.push_back('{32'h00208033, mk(3'd0, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0)});
      vt.push_back('{32'h022081B3, mk(3'd7, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 1'b1)});
      vt.push_back('{32'hFFE1F113, mk(3'd2, 5'd3, 5'd0, 5'd2, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0)});

      // Back-to-back table vectors, one bundle per cycle with out_ready high.
      for (int i = 0; i < vt.size(); i++) begin
         step(1'b1, vt[i].instr, 1'b1, 1'b0);
         cmp($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
         cmp($sformatf("vec%0d_bundle", i), 64'(dut_bundle()), 64'(vt[i].exp));
      end
      step(1'b0, '0, 1'b1, 1'b0);
      cmp("drained", 64'(bus.out_valid), 64'd0);

      // Backpressure: two accepted, third stalled, head held stable.
      step(1'b1, 32'h00208093, 1'b0, 1'b0);
      first_b = dut_bundle();
      step(1'b1, 32'h00208113, 1'b0, 1'b0);
      cmp("bp_in_ready_two", 64'(in_ready), 64'd0);
      step(1'b1, 32'h00208193, 1'b0, 1'b0);
      cmp("bp_head_stable", 64'(dut_bundle()), 64'(first_b));
      cmp("bp_head_rd", 64'(bus.rd), 64'd1);
      step(1'b1, 32'h00208193, 1'b1, 1'b0);
      cmp("bp_second_rd", 64'(bus.rd), 64'd2);
      step(1'b1, 32'h00208193, 1'b1, 1'b0);
      cmp("bp_third_rd", 64'(bus.rd), 64'd3);
      step(1'b0, '0, 1'b1, 1'b0);
      cmp("bp_no_dup", 64'(bus.out_valid), 64'd0);

      // Flush in TWO with an instruction offered in the flush cycle.
      step(1'b1, 32'h00208213, 1'b0, 1'b0);
      step(1'b1, 32'h00208293, 1'b0, 1'b0);
      step(1'b1, 32'h00208313, 1'b0, 1'b1);
      cmp("flush_out_valid", 64'(bus.out_valid), 64'd0);
      cmp("flush_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] w;
         logic [6:0]  op, f7;
         w = $urandom;
         case ($urandom_range(0, 3))
            0, 1: op = 7'h33;
            2:    op = 7'h13;
            default: op = w[6:0];
         endcase
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1, 2: f7 = 7'h20;
            default: f7 = w[31:25];
         endcase
         w[6:0] = op;
         w[31:25] = f7;
         step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 40) == 0));
      end

      // Asynchronous reset mid-operation drops out_valid without a clock edge.
      step(1'b1, 32'h002081B3, 1'b0, 1'b0);
      step(1'b1, 32'h402081B3, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      cmp("async_rst_valid", 64'(bus.out_valid), 64'd0);
      cmp("async_rst_ready", 64'(in_ready), 64'd1);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 32'h0020C233, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
